// File: rtl/maze_port_arbiter.sv
// maze_port_arbiter: lets two maze walkers share one single-bit maze port.
// Each access takes three cycles: IDLE (arbitrate), ACCESS (drive the port),
// and CAPTURE (read data lands). Walkers that have reported done are masked
// out. Once both walkers are done the arbiter stays parked in IDLE.
//
// Handshake: a walker raises reqN with weN/rowN/colN and holds them stable
// until it sees gntN. gntN is a one-cycle pulse in the cycle the maze port is
// driven. For a read, rdvN pulses two cycles after gntN, and rd_data then
// holds the cell value (1 = wall). A write produces no rdvN pulse. reqN is
// only looked at while the arbiter is in IDLE.
module maze_port_arbiter #(
  parameter int maze_width = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [maze_width-1:0] row0,
  input  logic [maze_width-1:0] col0,
  input  logic [maze_width-1:0] row1,
  input  logic [maze_width-1:0] col1,
  input  logic                  done0,
  input  logic                  done1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rdv0,
  output logic                  rdv1,
  output logic                  rd_data,
  output logic [maze_width-1:0] row,
  output logic [maze_width-1:0] col,
  output logic                  maze_oe,
  output logic                  maze_we,
  input  logic                  maze_in,
  output logic [15:0]           acc_cnt0,
  output logic [15:0]           acc_cnt1,
  output logic [1:0]            first_done,
  output logic                  all_done,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;     // 0 = walker 0, 1 = walker 1
  logic                  lp_q, lp_d;       // last-granted walker
  logic                  we_q, we_d;
  logic [maze_width-1:0] row_q, row_d;
  logic [maze_width-1:0] col_q, col_d;
  logic                  rd_data_q, rd_data_d;
  logic [1:0]            rdv_q, rdv_d;
  logic [15:0]           acc_cnt0_q, acc_cnt0_d;
  logic [15:0]           acc_cnt1_q, acc_cnt1_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            first_done_q, first_done_d;
  logic [1:0]            elig;
  logic                  in_access;
  logic                  rd_capture;

  assign in_access  = (state_q == ACCESS);
  assign rd_capture = (state_q == CAPTURE) && !we_q;

  // Next-state logic: arbitration in IDLE, fixed walk through ACCESS and CAPTURE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lp_d    = lp_q;
    we_d    = we_q;
    row_d   = row_q;
    col_d   = col_q;
    elig    = {req1 & ~done_q[1], req0 & ~done_q[0]};
    case (state_q)
      IDLE: begin
        if (!all_done && (elig != 2'b00)) begin
          state_d = ACCESS;
          // On a tie the walker that did not go last wins.
          if (elig == 2'b11) sel_d = ~lp_q;
          else               sel_d = elig[1];
          we_d  = sel_d ? we1  : we0;
          row_d = sel_d ? row1 : row0;
          col_d = sel_d ? col1 : col0;
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
        lp_d    = sel_q;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: read capture, counters, sticky done tracking.
  always_comb begin
    rd_data_d    = rd_capture ? maze_in : rd_data_q;
    rdv_d        = rd_capture ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    acc_cnt0_d   = (gnt0 && (acc_cnt0_q != 16'hFFFF)) ? acc_cnt0_q + 16'd1 : acc_cnt0_q;
    acc_cnt1_d   = (gnt1 && (acc_cnt1_q != 16'hFFFF)) ? acc_cnt1_q + 16'd1 : acc_cnt1_q;
    done_d       = done_q | {done1, done0};
    // first_done records whichever latched first and is frozen afterwards.
    first_done_d = (first_done_q == 2'b00) ? {done1, done0} : first_done_q;
  end

  // State and datapath registers; reset dominates and aborts any access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      lp_q         <= 1'b1;
      we_q         <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      rd_data_q    <= 1'b0;
      rdv_q        <= 2'b00;
      acc_cnt0_q   <= 16'd0;
      acc_cnt1_q   <= 16'd0;
      done_q       <= 2'b00;
      first_done_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      lp_q         <= lp_d;
      we_q         <= we_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rd_data_q    <= rd_data_d;
      rdv_q        <= rdv_d;
      acc_cnt0_q   <= acc_cnt0_d;
      acc_cnt1_q   <= acc_cnt1_d;
      done_q       <= done_d;
      first_done_q <= first_done_d;
    end
  end

  assign gnt0        = in_access & ~sel_q;
  assign gnt1        = in_access &  sel_q;
  assign maze_oe     = in_access & ~we_q;
  assign maze_we     = in_access &  we_q;
  assign row         = row_q;
  assign col         = col_q;
  assign rdv0        = rdv_q[0];
  assign rdv1        = rdv_q[1];
  assign rd_data     = rd_data_q;
  assign acc_cnt0    = acc_cnt0_q;
  assign acc_cnt1    = acc_cnt1_q;
  assign first_done  = first_done_q;
  assign all_done    = &done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Bench for maze_port_arbiter: cycle-by-cycle vector table plus a
// counter-saturation sequence.
module tb_maze_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, req0, req1, we0, we1, done0, done1, maze_in;
  logic [5:0] row0, col0, row1, col1;
  logic       gnt0, gnt1, rdv0, rdv1, rd_data, maze_oe, maze_we, all_done;
  logic [5:0] row, col;
  logic [15:0] acc_cnt0, acc_cnt1;
  logic [1:0] first_done, dbg_state;

  int errors = 0;
  int checks = 0;

  // Clock generation.
  always #5 clk = ~clk;

  maze_port_arbiter #(.maze_width(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .row0(row0), .col0(col0), .row1(row1), .col1(col1),
    .done0(done0), .done1(done1),
    .gnt0(gnt0), .gnt1(gnt1), .rdv0(rdv0), .rdv1(rdv1), .rd_data(rd_data),
    .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
    .maze_in(maze_in),
    .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1),
    .first_done(first_done), .all_done(all_done),
    .dbg_state_o(dbg_state)
  );

  // One record per clock cycle: inputs driven in that cycle and the
  // outputs expected during that same cycle.
  // ctl = {gnt0,gnt1, rdv0,rdv1, rd_data, maze_oe, maze_we, first_done[1:0], all_done}
  typedef struct {
    logic        rst_n;
    logic [1:0]  req;     // {req0,req1}
    logic [1:0]  we;      // {we0,we1}
    logic [5:0]  row0, col0, row1, col1;
    logic [1:0]  dn;      // {done0,done1}
    logic        maze_in;
    logic        chk;
    logic [9:0]  exp_ctl;
    logic [5:0]  exp_row, exp_col;
    logic [15:0] exp_cnt0, exp_cnt1;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic [1:0] rq, input logic [1:0] w,
                   input logic [5:0] r0, input logic [5:0] c0,
                   input logic [5:0] r1, input logic [5:0] c1,
                   input logic [1:0] dn, input logic mi, input logic chk,
                   input logic [9:0] ctl, input logic [5:0] er, input logic [5:0] ec,
                   input logic [15:0] n0, input logic [15:0] n1);
    vec_t t;
    t.rst_n = r; t.req = rq; t.we = w;
    t.row0 = r0; t.col0 = c0; t.row1 = r1; t.col1 = c1;
    t.dn = dn; t.maze_in = mi; t.chk = chk;
    t.exp_ctl = ctl; t.exp_row = er; t.exp_col = ec;
    t.exp_cnt0 = n0; t.exp_cnt1 = n1;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.rst_n;
    {req0, req1} = t.req;
    {we0, we1} = t.we;
    row0 = t.row0; col0 = t.col0; row1 = t.row1; col1 = t.col1;
    {done0, done1} = t.dn;
    maze_in = t.maze_in;
  endtask

  localparam logic [9:0] Z   = 10'b00_00_0_0_0_00_0;
  localparam logic [9:0] D1  = 10'b00_00_1_0_0_00_0;

  initial begin
    logic [9:0] act_ctl;
    vec_t       t;
    int         n;
    logic [15:0] exp_c;

    // reset, then single read by walker 0 at (5,7), maze_in=1
    v(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, Z, 0, 0, 0, 0);
    v(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, Z, 0, 0, 0, 0);
    v(1, 2'b10, 2'b00, 5, 7, 0, 0, 2'b00, 0, 1, Z, 0, 0, 0, 0);
    v(1, 2'b00, 2'b00, 5, 7, 0, 0, 2'b00, 0, 1, 10'b10_00_0_1_0_00_0, 5, 7, 0, 0);
    v(1, 2'b00, 2'b00, 5, 7, 0, 0, 2'b00, 1, 1, Z, 5, 7, 1, 0);
    v(1, 2'b00, 2'b00, 5, 7, 0, 0, 2'b00, 0, 1, 10'b00_10_1_0_0_00_0, 5, 7, 1, 0);
    v(1, 2'b00, 2'b00, 5, 7, 0, 0, 2'b00, 0, 1, D1, 5, 7, 1, 0);
    // write by walker 1 at (9,3): maze_we, no rdv, rd_data kept
    v(1, 2'b01, 2'b01, 0, 0, 9, 3, 2'b00, 0, 1, D1, 5, 7, 1, 0);
    v(1, 2'b00, 2'b01, 0, 0, 9, 3, 2'b00, 0, 1, 10'b01_00_1_0_1_00_0, 9, 3, 1, 0);
    v(1, 2'b00, 2'b01, 0, 0, 9, 3, 2'b00, 0, 1, D1, 9, 3, 1, 1);
    v(1, 2'b00, 2'b00, 0, 0, 9, 3, 2'b00, 0, 1, D1, 9, 3, 1, 1);
    // reset, then contention with both requests held: 0,1,0
    v(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, D1, 9, 3, 1, 1);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, Z, 0, 0, 0, 0);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b10_00_0_1_0_00_0, 1, 2, 0, 0);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, Z, 1, 2, 1, 0);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_10_0_0_0_00_0, 1, 2, 1, 0);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b01_00_0_1_0_00_0, 3, 4, 1, 0);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 1, 1, Z, 3, 4, 1, 1);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_01_1_0_0_00_0, 3, 4, 1, 1);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b10_00_1_1_0_00_0, 1, 2, 1, 1);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, D1, 1, 2, 2, 1);
    v(1, 2'b00, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_10_0_0_0_00_0, 1, 2, 2, 1);
    v(1, 2'b00, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, Z, 1, 2, 2, 1);
    // done0 pulse masks walker 0; done1 during its own capture still delivers rdv1
    v(1, 2'b00, 2'b00, 1, 2, 3, 4, 2'b10, 0, 1, Z, 1, 2, 2, 1);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_00_0_0_0_01_0, 1, 2, 2, 1);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b01_00_0_1_0_01_0, 3, 4, 2, 1);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 1, 1, 10'b00_00_0_0_0_01_0, 3, 4, 2, 2);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_01_1_0_0_01_0, 3, 4, 2, 2);
    v(1, 2'b00, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b01_00_1_1_0_01_0, 3, 4, 2, 2);
    v(1, 2'b00, 2'b00, 1, 2, 3, 4, 2'b01, 0, 1, 10'b00_00_1_0_0_01_0, 3, 4, 2, 3);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_01_0_0_0_01_1, 3, 4, 2, 3);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_00_0_0_0_01_1, 3, 4, 2, 3);
    v(1, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_00_0_0_0_01_1, 3, 4, 2, 3);
    // reset, grant walker 0, reset during ACCESS aborts it
    v(0, 2'b11, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, 10'b00_00_0_0_0_01_1, 3, 4, 2, 3);
    v(1, 2'b10, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, Z, 0, 0, 0, 0);
    v(0, 2'b10, 2'b00, 1, 2, 3, 4, 2'b00, 1, 1, 10'b10_00_0_1_0_00_0, 1, 2, 0, 0);
    v(1, 2'b00, 2'b00, 1, 2, 3, 4, 2'b00, 1, 1, Z, 0, 0, 0, 0);
    v(1, 2'b00, 2'b00, 1, 2, 3, 4, 2'b00, 1, 1, Z, 0, 0, 0, 0);
    v(1, 2'b00, 2'b00, 1, 2, 3, 4, 2'b00, 0, 1, Z, 0, 0, 0, 0);
    // both done in the same cycle gives first_done=11
    v(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 0, 1, Z, 0, 0, 0, 0);
    v(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 10'b00_00_0_0_0_11_1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t);
      #1;
      if (t.chk) begin
        act_ctl = {gnt0, gnt1, rdv0, rdv1, rd_data, maze_oe, maze_we, first_done, all_done};
        check($sformatf("ctl[%0d]", i), {22'd0, act_ctl}, {22'd0, t.exp_ctl});
        check($sformatf("rowcol[%0d]", i), {20'd0, row, col}, {20'd0, t.exp_row, t.exp_col});
        check($sformatf("cnt[%0d]", i), {acc_cnt0, acc_cnt1}, {t.exp_cnt0, t.exp_cnt1});
        if (i == 1) check("state_after_reset", {30'd0, dbg_state}, 32'd0);
      end
      @(negedge clk);
    end

    // Saturation: preload walker 0's counter near the top, then grant 4 times.
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    done0 = 1'b0; done1 = 1'b0; maze_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    force dut.acc_cnt0_q = 16'hFFFD;
    @(negedge clk);
    release dut.acc_cnt0_q;
    req0 = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (gnt0 !== 1'b1 && n < 10) begin
        @(negedge clk); #1;
        n++;
      end
      if (n >= 10) begin
        errors++;
        checks++;
        $display("FAIL sat_gnt_timeout: no gnt0 within 10 cycles, grant %0d", g);
      end
      check($sformatf("sat_no_gnt1[%0d]", g), {31'd0, gnt1}, 32'd0);
      @(negedge clk); #1;
      exp_c = (g == 0) ? 16'hFFFE : 16'hFFFF;
      check($sformatf("sat_cnt0[%0d]", g), {16'd0, acc_cnt0}, {16'd0, exp_c});
    end
    req0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
